// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: shares one DDR2 app port between the program loader (port 0)
// and the core memory path (port 1). One transaction in flight at a time;
// round-robin or fixed-priority grant; a watchdog forces completion if the
// DDR response is lost.
module ddr_req_arbiter #(
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 128,
  parameter int FIXED_PRIO  = 0,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_we,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_resp_valid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_we,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_resp_valid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic              gid_q, gid_d;        // port owning the in-flight transaction
  logic              last_q, last_d;      // most recent grant, for round-robin
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  wd_q, wd_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              terr_q, terr_d;

  logic gnt_vld;
  logic gnt_id;

  // Grant decision; ready is a same-cycle accept, so it is decoded from live
  // request inputs and masked during reset so nothing is accepted and dropped.
  always_comb begin
    gnt_vld = !rst && (state_q == IDLE) && (p0_req_valid || p1_req_valid);
    gnt_id  = 1'b0;
    if (p0_req_valid && p1_req_valid)
      gnt_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    else
      gnt_id = p1_req_valid;
  end

  assign p0_req_ready  = gnt_vld && !gnt_id;
  assign p1_req_ready  = gnt_vld &&  gnt_id;
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign p0_resp_valid = (state_q == RESP) && !gid_q;
  assign p1_resp_valid = (state_q == RESP) &&  gid_q;
  assign p0_rdata      = rdata0_q;
  assign p1_rdata      = rdata1_q;
  assign busy          = (state_q != IDLE);
  assign timeout_err   = terr_q;

  // Next-state and capture logic for the single-outstanding transaction FSM.
  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    last_d   = last_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wd_d     = wd_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    terr_d   = terr_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          gid_d   = gnt_id;
          last_d  = gnt_id;
          addr_d  = gnt_id ? p1_addr  : p0_addr;
          we_d    = gnt_id ? p1_we    : p0_we;
          wdata_d = gnt_id ? p1_wdata : p0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          wd_d    = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        wd_d = wd_q + CNT_W'(1);
        if (mem_resp_valid) begin
          // Write acks carry no data; hand back zero rather than bus noise.
          if (gid_q) rdata1_d = we_q ? '0 : mem_rdata;
          else       rdata0_d = we_q ? '0 : mem_rdata;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          if (gid_q) rdata1_d = '0;
          else       rdata0_d = '0;
          terr_d  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gid_q    <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wd_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wd_q     <= wd_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      terr_q   <= terr_d;
    end
  end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed bench for ddr_req_arbiter: a round-robin instance with a short
// watchdog, plus a fixed-priority twin sharing the same stimulus.
module tb_ddr_req_arbiter;
  localparam int AW = 27;
  localparam int DW = 128;

  logic          clk, rst;
  logic          p0_req_valid, p0_we, p1_req_valid, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          mem_req_ready, mem_resp_valid;
  logic [DW-1:0] mem_rdata;

  logic          p0_req_ready, p0_resp_valid, p1_req_ready, p1_resp_valid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_req_valid, mem_we, busy, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  logic          fp_p0_req_ready, fp_p0_resp_valid, fp_p1_req_ready, fp_p1_resp_valid;
  logic [DW-1:0] fp_p0_rdata, fp_p1_rdata;
  logic          fp_mem_req_valid, fp_mem_we, fp_busy, fp_timeout_err;
  logic [AW-1:0] fp_mem_addr;
  logic [DW-1:0] fp_mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [DW-1:0] DEADBEEF = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;

  ddr_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_addr(p0_addr),
    .p0_we(p0_we), .p0_wdata(p0_wdata), .p0_resp_valid(p0_resp_valid), .p0_rdata(p0_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_addr(p1_addr),
    .p1_we(p1_we), .p1_wdata(p1_wdata), .p1_resp_valid(p1_resp_valid), .p1_rdata(p1_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .busy(busy), .timeout_err(timeout_err)
  );

  ddr_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1), .TIMEOUT_CYC(16)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(fp_p0_req_ready), .p0_addr(p0_addr),
    .p0_we(p0_we), .p0_wdata(p0_wdata), .p0_resp_valid(fp_p0_resp_valid), .p0_rdata(fp_p0_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(fp_p1_req_ready), .p1_addr(p1_addr),
    .p1_we(p1_we), .p1_wdata(p1_wdata), .p1_resp_valid(fp_p1_resp_valid), .p1_rdata(fp_p1_rdata),
    .mem_req_valid(fp_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(fp_mem_addr),
    .mem_we(fp_mem_we), .mem_wdata(fp_mem_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .busy(fp_busy), .timeout_err(fp_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    p0_req_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    tick(); tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_resp", {p0_resp_valid, p1_resp_valid}, 0);
    chk("rst_ready", {p0_req_ready, p1_req_ready}, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_rdata", p0_rdata | p1_rdata, 0);
    rst = 1'b0;
    tick();

    // Test 2: both ports requesting continuously; RR alternates, fixed keeps p0
    p0_req_valid = 1; p0_addr = 27'hA0;
    p1_req_valid = 1; p1_addr = 27'hB0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_rr_p0_ready", p0_req_ready, (k % 2) == 0);
      chk("t2_rr_p1_ready", p1_req_ready, (k % 2) == 1);
      chk("t2_fp_p0_ready", fp_p0_req_ready, 1);
      tick();
      chk("t2_rr_addr", mem_addr, (k % 2) ? 27'hB0 : 27'hA0);
      chk("t2_fp_addr", fp_mem_addr, 27'hA0);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 128'h100 + 128'(k);
      tick();
      mem_resp_valid = 0;
      if (k % 2) begin
        chk("t2_p1_resp", {p0_resp_valid, p1_resp_valid}, 2'b01);
        chk("t2_p1_rdata", p1_rdata, 128'h100 + 128'(k));
      end else begin
        chk("t2_p0_resp", {p0_resp_valid, p1_resp_valid}, 2'b10);
        chk("t2_p0_rdata", p0_rdata, 128'h100 + 128'(k));
      end
      chk("t2_fp_p0_resp", fp_p0_resp_valid, 1);
      tick();
    end
    p0_req_valid = 0; p1_req_valid = 0;
    tick();

    // Test 1: single read from p1, DDR answers 5 cycles after accept
    p1_req_valid = 1; p1_addr = 27'h100; p1_we = 0;
    #1;
    chk("t1_p1_ready", p1_req_ready, 1);
    chk("t1_p0_ready", p0_req_ready, 0);
    chk("t1_memv_t0", mem_req_valid, 0);
    tick();                                   // t+1
    p1_req_valid = 0;
    chk("t1_memv_t1", mem_req_valid, 1);
    chk("t1_addr", mem_addr, 27'h100);
    chk("t1_we", mem_we, 0);
    chk("t1_p1_ready_drop", p1_req_ready, 0);
    mem_req_ready = 1;
    tick();                                   // t+2, WAIT
    mem_req_ready = 0;
    chk("t1_memv_wait", mem_req_valid, 0);
    tick(); tick(); tick();                   // t+5
    mem_resp_valid = 1; mem_rdata = DEADBEEF;
    chk("t1_no_early_resp", p1_resp_valid, 0);
    tick();                                   // t+6, RESP
    mem_resp_valid = 0; mem_rdata = '0;
    chk("t1_p1_resp", p1_resp_valid, 1);
    chk("t1_p1_rdata", p1_rdata, DEADBEEF);
    chk("t1_p0_silent", p0_resp_valid, 0);
    chk("t1_p0_rdata_held", p0_rdata, 128'h102);
    tick();
    chk("t1_pulse_one", p1_resp_valid, 0);
    chk("t1_rdata_held", p1_rdata, DEADBEEF);
    chk("t1_idle", busy, 0);

    // Test 3: p0 write with DDR back-pressure for 3 cycles
    p0_req_valid = 1; p0_we = 1; p0_addr = 27'h40; p0_wdata = 128'h1234;
    #1;
    chk("t3_p0_ready", p0_req_ready, 1);
    tick();
    p0_req_valid = 0; p0_we = 0; p0_addr = 27'h7FF; p0_wdata = 128'hFFFF;
    for (int i = 0; i < 3; i++) begin
      chk("t3_memv_held", mem_req_valid, 1);
      chk("t3_addr_held", mem_addr, 27'h40);
      chk("t3_we_held", mem_we, 1);
      chk("t3_wdata_held", mem_wdata, 128'h1234);
      tick();
    end
    chk("t3_memv_still", mem_req_valid, 1);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 128'hABCD;
    tick();
    mem_resp_valid = 0;
    chk("t3_p0_resp", p0_resp_valid, 1);
    chk("t3_p0_rdata_zero", p0_rdata, 0);
    chk("t3_p1_silent", p1_resp_valid, 0);
    tick();

    // Test 4: watchdog expiry on a lost read response
    p1_req_valid = 1; p1_addr = 27'h200; p1_we = 0;
    tick();
    p1_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    for (int i = 0; i < 16; i++) begin
      chk("t4_wait_no_resp", p1_resp_valid, 0);
      chk("t4_wait_no_terr", timeout_err, 0);
      tick();
    end
    chk("t4_to_resp", p1_resp_valid, 1);
    chk("t4_to_rdata", p1_rdata, 0);
    chk("t4_terr_set", timeout_err, 1);
    tick();
    p0_req_valid = 1; p0_addr = 27'h10;
    tick();
    p0_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 128'h55;
    tick();
    mem_resp_valid = 0;
    chk("t4_normal_resp", p0_resp_valid, 1);
    chk("t4_normal_rdata", p0_rdata, 128'h55);
    chk("t4_terr_sticky", timeout_err, 1);
    tick();

    // Test 6: spurious response while idle
    mem_resp_valid = 1; mem_rdata = 128'h77;
    tick();
    mem_resp_valid = 0;
    chk("t6_no_resp", {p0_resp_valid, p1_resp_valid}, 0);
    chk("t6_idle", busy, 0);
    tick();
    chk("t6_no_resp_late", {p0_resp_valid, p1_resp_valid}, 0);
    chk("t6_rdata_held", p0_rdata, 128'h55);

    // Test 5: reset in WAIT aborts; late response ignored; next tie to p0
    p1_req_valid = 1; p1_addr = 27'h300;
    tick();
    p1_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    chk("t5_in_wait", busy, 1);
    rst = 1;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_memv", mem_req_valid, 0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_resp", {p0_resp_valid, p1_resp_valid}, 0);
    chk("t5_terr_clr", timeout_err, 0);
    chk("t5_rdata_clr", p0_rdata | p1_rdata, 0);
    rst = 0; mem_resp_valid = 1; mem_rdata = 128'h99;
    tick();
    mem_resp_valid = 0;
    chk("t5_late_ignored", {p0_resp_valid, p1_resp_valid}, 0);
    chk("t5_late_idle", busy, 0);
    p0_req_valid = 1; p1_req_valid = 1;
    #1;
    chk("t5_tie_p0", {p0_req_ready, p1_req_ready}, 2'b10);
    tick();
    p0_req_valid = 0; p1_req_valid = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
